// File: rtl/seq_div.sv
// ---------------------------------------------------------------------------
// seq_div - multi-cycle restoring shift-subtract divider.
//
// Divides an A_width-bit dividend by a B_width-bit divisor, one quotient bit
// per clock. TC selects unsigned (0) or two's-complement (1) operation. The
// operands are converted to magnitudes on the accepting edge, the magnitudes
// are divided unsigned, and the signs are reapplied in a final fix-up cycle
// (quotient truncates toward zero, remainder takes the dividend's sign).
//
// Timeline: accepting edge 0, iterations on edges 1..A_width, results and
// the one-cycle done pulse on edge A_width+1.
//
// Ports:
//   clk          in   1        system clock, rising edge
//   reset        in   1        asynchronous, active-high reset
//   start        in   1        request, only honoured while idle
//   A            in   A_width  dividend, sampled on the accepting edge
//   B            in   B_width  divisor, sampled on the accepting edge
//   TC           in   1        1 = two's-complement, 0 = unsigned
//   busy         out  1        division in progress
//   done         out  1        one-cycle pulse, results valid
//   QUOTIENT     out  A_width  quotient, held until the next FIX cycle
//   REMAINDER    out  B_width  remainder, held until the next FIX cycle
//   DIV_BY_ZERO  out  1        divisor was zero, held with the results
// ---------------------------------------------------------------------------
module seq_div #(
    parameter int A_width = 16,
    parameter int B_width = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [A_width-1:0] A,
    input  logic [B_width-1:0] B,
    input  logic               TC,
    output logic               busy,
    output logic               done,
    output logic [A_width-1:0] QUOTIENT,
    output logic [B_width-1:0] REMAINDER,
    output logic               DIV_BY_ZERO
);

    localparam int CNT_W = (A_width > 2) ? $clog2(A_width) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_zero;
    logic [B_width-1:0] r_rem;
    logic [A_width-1:0] r_dvd;
    logic [B_width-1:0] r_mag_b;

    logic               w_accept;
    logic [B_width:0]   w_rem_sh;
    logic               w_ge;
    logic [B_width-1:0] w_rem_sub;

    // Conditional two's-complement negate. The most negative value maps onto
    // itself, which read as unsigned is exactly 2^(width-1): no saturation.
    function automatic logic [A_width-1:0] f_sign_a(input logic [A_width-1:0] v,
                                                    input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [B_width-1:0] f_sign_b(input logic [B_width-1:0] v,
                                                    input logic neg);
        return neg ? -v : v;
    endfunction

    assign w_accept = (r_state == S_IDLE) && start;

    // Shift the next dividend bit into the partial remainder. The partial
    // remainder is always below |B|, so the subtraction result fits in
    // B_width bits and the carry bit of the shifted value is only needed
    // for the comparison.
    assign w_rem_sh  = {r_rem, r_dvd[A_width-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_mag_b});
    assign w_rem_sub = w_rem_sh[B_width-1:0] - r_mag_b;

    // Datapath: operand capture on accept, one restoring iteration per CALC
    // cycle. r_dvd shifts the dividend out and the quotient bits in.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_sign_q <= TC & (A[A_width-1] ^ B[B_width-1]);
            r_sign_r <= TC & A[A_width-1];
            r_dvd    <= f_sign_a(A, TC & A[A_width-1]);
            r_mag_b  <= f_sign_b(B, TC & B[B_width-1]);
            r_zero   <= (B == '0);
            r_rem    <= '0;
        end else if (r_state == S_CALC) begin
            r_rem <= w_ge ? w_rem_sub : w_rem_sh[B_width-1:0];
            r_dvd <= {r_dvd[A_width-2:0], w_ge};
        end
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            QUOTIENT    <= '0;
            REMAINDER   <= '0;
            DIV_BY_ZERO <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(A_width - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // A zero divisor overrides the natural restoring result.
                    if (r_zero) begin
                        QUOTIENT  <= '1;
                        REMAINDER <= '0;
                    end else begin
                        QUOTIENT  <= f_sign_a(r_dvd, r_sign_q);
                        REMAINDER <= f_sign_b(r_rem, r_sign_r);
                    end
                    DIV_BY_ZERO <= r_zero;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
